// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register, ARM condition evaluation and write-strobe gating
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter logic       NV_EXEC    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);
  logic n, z, c, v;
  assign {n, z, c, v} = Flags;
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'h0: CondEx = z;
      4'h1: CondEx = ~z;
      4'h2: CondEx = c;
      4'h3: CondEx = ~c;
      4'h4: CondEx = n;
      4'h5: CondEx = ~n;
      4'h6: CondEx = v;
      4'h7: CondEx = ~v;
      4'h8: CondEx = c & ~z;
      4'h9: CondEx = ~c | z;
      4'hA: CondEx = n == v;
      4'hB: CondEx = n != v;
      4'hC: CondEx = ~z & (n == v);
      4'hD: CondEx = z | (n != v);
      4'hE: CondEx = 1'b1;
      4'hF: CondEx = NV_EXEC;
      default: CondEx = 1'b0;
    endcase
  end
  assign PCSrc    = reset & PCS & CondEx;
  assign RegWrite = reset & RegW & CondEx & ~NoWrite;
  assign MemWrite = reset & MemW & CondEx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Flags <= FLAG_RESET;
    else begin
      if (FlagW[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
    end
  end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed vectors with a queue-based scoreboard for cond_logic
module tb_cond_logic;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'hE, ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] e;
  } exp_t;

  exp_t q[$];
  event smp;
  int   tests = 0;
  int   fails = 0;

  // expected word is {CondEx, PCSrc, RegWrite, MemWrite, Flags}
  task automatic vec(input string nm, input logic rst, input logic [3:0] cnd,
                     input logic [3:0] alu, input logic [1:0] fw,
                     input logic pcs, input logic regw, input logic memw,
                     input logic nw, input logic [7:0] e);
    exp_t x;
    @(negedge clk);
    reset = rst; Cond = cnd; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nw;
    x.nm = nm; x.e = e;
    q.push_back(x);
    -> smp;
  endtask

  initial begin
    exp_t x;
    logic [7:0] got;
    forever begin
      @(smp);
      #1;
      got = {CondEx, PCSrc, RegWrite, MemWrite, Flags};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow got=%b", got);
      end else begin
        x = q.pop_front();
        if (got !== x.e) begin
          fails++;
          $display("FAIL %s got=%b expected=%b", x.nm, got, x.e);
        end
      end
    end
  end

  logic [15:0] masks [7] = '{16'h56AA, 16'h66A9, 16'h6A9A, 16'h55A6, 16'h565A, 16'h6A6A, 16'h66A5};
  logic [3:0]  fv    [7] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b1001, 4'b0001, 4'b0110};

  initial begin
    logic [3:0] prev;
    logic       m;
    #1 reset = 1'b0;
    // reset hold and release
    vec("rst_hold0", 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 8'b1000_0000);
    vec("rst_hold1", 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 8'b1000_0000);
    vec("rst_rel",   1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 8'b1010_0000);
    // failed condition blocks flag load
    vec("eq_fail",   1, 4'h0, 4'b0100, 2'b11, 0, 0, 0, 0, 8'b0000_0000);
    vec("al_load",   1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 8'b1000_0000);
    vec("eq_pass",   1, 4'h0, 4'b0100, 2'b00, 0, 0, 0, 0, 8'b1000_0100);
    // independent halves
    vec("clr",       1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 8'b1000_0100);
    vec("nz_only",   1, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0, 8'b1000_0000);
    vec("cv_only",   1, 4'hE, 4'b0011, 2'b01, 0, 0, 0, 0, 8'b1000_1100);
    vec("half_chk",  1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 8'b1000_1111);
    // condition sweep
    prev = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      vec($sformatf("load_%b", fv[i]), 1, 4'hE, fv[i], 2'b11, 0, 0, 0, 0, {4'b1000, prev});
      for (int c = 0; c < 16; c++) begin
        m = masks[i][c];
        vec($sformatf("sweep_f%b_c%h", fv[i], c[3:0]), 1, c[3:0], 4'b1111, 2'b00, 1, 1, 1, 0,
            {m, m, m, m, fv[i]});
      end
      prev = fv[i];
    end
    // compare-class op and NV
    vec("cmp",       1, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 1, 8'b1000_0110);
    vec("nv",        1, 4'hF, 4'b0101, 2'b11, 1, 1, 1, 0, 8'b0000_1010);
    vec("nv_hold",   1, 4'hE, 4'b0000, 2'b00, 1, 1, 1, 0, 8'b1111_1010);
    // async reset mid-cycle
    vec("arst_mid",  0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 8'b1000_0000);
    vec("arst_ne",   0, 4'h1, 4'b1111, 2'b11, 1, 1, 1, 0, 8'b1000_0000);
    vec("arst_eq",   0, 4'h0, 4'b1111, 2'b11, 1, 1, 1, 0, 8'b0000_0000);
    vec("arst_rel",  1, 4'hE, 4'b0000, 2'b00, 1, 1, 1, 0, 8'b1111_0000);
    #5;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
